// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier beside the EX-stage ALU.
// Stalls the pipeline while it forms the low WIDTH bits of A*B.
module mul_sequencer #(
    parameter int          WIDTH      = 32,
    parameter logic [5:0]  MUL_CODE   = 6'b011000,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [5:0]       ALUControl,
    input  logic             Valid_in,
    input  logic             Flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_count;
    logic             r_done;
    logic [WIDTH-1:0] r_result;

    logic             w_start;
    logic             w_run;
    logic             w_last;
    logic             w_fin;
    logic [WIDTH-1:0] w_sum;

    // Rst_n in start keeps Stall low while reset is held
    assign w_start = Rst_n && (r_state == S_IDLE) && Valid_in
                     && (ALUControl == MUL_CODE) && !Flush;
    assign w_run   = (r_state == S_RUN) && !Flush;
    assign w_sum   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_last  = (r_count == CW'(WIDTH - 1))
                     || (EARLY_EXIT && ((r_mplier >> 1) == '0));
    assign w_fin   = w_run && w_last;

    assign Stall  = w_start || w_run;
    assign Done   = r_done;
    assign Result = r_result;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_start) w_next = S_RUN;
            S_RUN: begin
                if (Flush)       w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= w_fin;
            if (w_start) begin
                r_acc    <= '0;
                r_mcand  <= A;
                r_mplier <= B;
                r_count  <= '0;
            end else if (w_run) begin
                r_acc    <= w_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + 1'b1;
            end
            if (w_fin) r_result <= w_sum;
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed and random checks of mul_sequencer against a
// plain-arithmetic model of product and iteration count.
module tb_mul_sequencer;

    localparam int         W   = 32;
    localparam logic [5:0] MUL = 6'b011000;
    localparam logic [5:0] ADD = 6'b100000;

    logic         Clk;
    logic         Rst_n;
    logic [5:0]   ALUControl;
    logic         Valid_in;
    logic         Flush;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Stall;
    logic         Done;
    logic [W-1:0] Result;

    int total = 0;
    int bad   = 0;

    mul_sequencer #(
        .WIDTH(W),
        .MUL_CODE(MUL),
        .EARLY_EXIT(1'b1)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .ALUControl(ALUControl),
        .Valid_in(Valid_in),
        .Flush(Flush),
        .A(A),
        .B(B),
        .Stall(Stall),
        .Done(Done),
        .Result(Result)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, got, exp);
        end
    endtask

    // Model: product mod 2^W; iterations = position of top set bit of b
    function automatic int model_runs(input logic [W-1:0] b);
        int msb = -1;
        for (int i = 0; i < W; i++)
            if (b[i]) msb = i;
        return (msb < 0) ? 1 : msb + 1;
    endfunction

    function automatic logic [W-1:0] model_prod(input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[W-1:0];
    endfunction

    // Called just after a posedge with the sequencer idle
    task automatic do_mul(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input string tag);
        int n = 0;
        int stall_err = 0;
        logic seen = 1'b0;
        logic [W-1:0] er = model_prod(a, b);
        int           en = model_runs(b);
        ALUControl = MUL;
        Valid_in   = 1'b1;
        A = a;
        B = b;
        #1;
        chk({tag, ".start_stall"}, W'(Stall), W'(1));
        for (int k = 0; k < W + 4; k++) begin
            @(posedge Clk);
            #1;
            if (Done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            n++;
            if (Stall !== 1'b1) stall_err++;
            A = $urandom;
            B = $urandom;
        end
        chk({tag, ".done_seen"}, W'(seen), W'(1));
        chk({tag, ".runs"}, W'(n), W'(en));
        chk({tag, ".run_stall"}, W'(stall_err), W'(0));
        chk({tag, ".result"}, Result, er);
        chk({tag, ".done_stall"}, W'(Stall), W'(0));
        @(posedge Clk);
        #1;
        Valid_in = 1'b0;
        chk({tag, ".done_clr"}, W'(Done), W'(0));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        Rst_n = 1'b0;
        ALUControl = '0;
        Valid_in = 1'b0;
        Flush = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst.stall", W'(Stall), W'(0));
        chk("rst.done", W'(Done), W'(0));
        chk("rst.result", Result, '0);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        do_mul(32'd7, 32'd6, "basic");

        // Flush on the third RUN cycle
        ALUControl = MUL;
        Valid_in = 1'b1;
        A = 32'd3;
        B = 32'hFF;
        repeat (3) @(posedge Clk);
        #1;
        Flush = 1'b1;
        #1;
        chk("flush.stall", W'(Stall), W'(0));
        @(posedge Clk);
        #1;
        Flush = 1'b0;
        Valid_in = 1'b0;
        chk("flush.done", W'(Done), W'(0));
        chk("flush.result", Result, 32'd42);
        @(posedge Clk);
        #1;
        chk("flush.idle_stall", W'(Stall), W'(0));

        do_mul(32'h00010000, 32'h80000000, "full");
        do_mul(32'hFFFFFFFD, 32'd5, "neg");
        do_mul(32'h0BADF00D, 32'd0, "zero");
        do_mul(32'h12345678, 32'd1, "one");

        do_mul(32'd5, 32'd5, "b2b_a");
        do_mul(32'd2, 32'd9, "b2b_b");

        ALUControl = ADD;
        Valid_in = 1'b1;
        A = 32'd1;
        B = 32'd1;
        #1;
        chk("add.stall", W'(Stall), W'(0));
        @(posedge Clk);
        #1;
        chk("add.done", W'(Done), W'(0));
        chk("add.result", Result, 32'd18);
        Valid_in = 1'b0;

        // Flush in IDLE suppresses start
        ALUControl = MUL;
        Valid_in = 1'b1;
        Flush = 1'b1;
        #1;
        chk("idle_flush.stall", W'(Stall), W'(0));
        @(posedge Clk);
        #1;
        Valid_in = 1'b0;
        Flush = 1'b0;
        #1;
        chk("idle_flush.after", W'(Stall), W'(0));

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            do_mul(ra, rb, "rand");
        end

        // Reset in the middle of a long multiply
        ALUControl = MUL;
        Valid_in = 1'b1;
        A = 32'h13579BDF;
        B = 32'hFFFFFFFF;
        repeat (5) @(posedge Clk);
        #1;
        Rst_n = 1'b0;
        #1;
        chk("mid_rst.stall", W'(Stall), W'(0));
        chk("mid_rst.done", W'(Done), W'(0));
        chk("mid_rst.result", Result, '0);
        #3;
        Valid_in = 1'b0;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("post_rst.done", W'(Done), W'(0));
        chk("post_rst.stall", W'(Stall), W'(0));
        do_mul(32'd9, 32'd11, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
